// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues req/ack instruction-memory requests and buffers
// fetched words in a 2-entry queue feeding decode. Handles decode redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        pcSrcD,
  input  logic [31:0] pcBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrF,
  output logic [31:0] pcPlus4F,
  output logic        validF
);

  typedef enum logic [1:0] {S_REQ, S_IDLE, S_DROP} state_e;

  state_e      state_q;
  logic        go_q;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic [1:0]  count_q;
  logic        head_q;
  logic        tail_q;
  logic [31:0] instr_mem_q [2];
  logic [31:0] pc4_mem_q   [2];

  logic        redirect;
  logic        ack_ok;
  logic        push;
  logic        pop;
  logic [31:0] pc_plus4;
  logic [1:0]  count_d;

  // go_q keeps the request low during reset and for the first cycle after it.
  assign imem_req  = go_q && (state_q != S_IDLE);
  assign imem_addr = pc_q;
  assign validF    = (count_q != 2'd0);
  assign instrF    = validF ? instr_mem_q[head_q] : 32'h0;
  assign pcPlus4F  = validF ? pc4_mem_q[head_q]   : 32'h0;

  // Redirect dominates: it suppresses both push and pop in the same cycle.
  assign redirect = go_q && pcSrcD;
  assign ack_ok   = imem_req && imem_ack;
  assign push     = ack_ok && (state_q == S_REQ) && !redirect;
  assign pop      = validF && !stallF && !redirect;
  assign pc_plus4 = pc_q + 32'd4;
  assign count_d  = count_q + {1'b0, push} - {1'b0, pop};

  // NOTE: queue storage carries no reset; instrF/pcPlus4F are masked by validF,
  // so stale contents are never visible and the array maps to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[tail_q] <= imem_rdata;
      pc4_mem_q[tail_q]   <= pc_plus4;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      go_q    <= 1'b0;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'h0;
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      go_q <= 1'b1;

      if (redirect) begin
        count_q <= 2'd0;
        head_q  <= 1'b0;
        tail_q  <= 1'b0;
      end else begin
        count_q <= count_d;
        if (push) tail_q <= ~tail_q;
        if (pop)  head_q <= ~head_q;
      end

      case (state_q)
        S_REQ: begin
          if (ack_ok) begin
            if (redirect) begin
              pc_q    <= pcBranchD;
              state_q <= S_REQ;
            end else begin
              pc_q    <= pc_plus4;
              state_q <= (count_d == 2'd2) ? S_IDLE : S_REQ;
            end
          end else if (redirect) begin
            tgt_q   <= pcBranchD;
            state_q <= S_DROP;
          end
        end
        S_IDLE: begin
          if (redirect) begin
            pc_q    <= pcBranchD;
            state_q <= S_REQ;
          end else if (pop) begin
            state_q <= S_REQ;
          end
        end
        S_DROP: begin
          // The in-flight request cannot be withdrawn; wait for its ack and discard it.
          if (ack_ok) begin
            pc_q    <= redirect ? pcBranchD : tgt_q;
            state_q <= S_REQ;
          end else if (redirect) begin
            tgt_q <= pcBranchD;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall fill/drain, redirects during
// pending requests, flush on ack, PC wrap and reset mid-request.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic        pcSrcD;
  logic [31:0] pcBranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instrF;
  logic [31:0] pcPlus4F;
  logic        validF;
  logic        ack_en;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stallF     (stallF),
    .pcSrcD     (pcSrcD),
    .pcBranchD  (pcBranchD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instrF     (instrF),
    .pcPlus4F   (pcPlus4F),
    .validF     (validF)
  );

  always #5 clk = ~clk;

  // Memory word at address A is {16'hC0DE, A[15:0]}.
  assign imem_ack   = ack_en && imem_req;
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stallF = 1'b0; pcSrcD = 1'b0; pcBranchD = 32'h0; ack_en = 1'b1;
    #3;
    check("rst_req",   {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, validF},   32'h0);
    check("rst_instr", instrF,            32'h0);
    check("rst_pc4",   pcPlus4F,          32'h0);
    check("rst_addr",  imem_addr,         32'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rel_req_low", {31'h0, imem_req}, 32'h0);

    // 1: zero-wait streaming
    tick();
    check("t1_req",  {31'h0, imem_req}, 32'h1);
    check("t1_a0",   imem_addr, 32'h0);
    check("t1_v0",   {31'h0, validF}, 32'h0);
    tick();
    check("t1_v1",   {31'h0, validF}, 32'h1);
    check("t1_i0",   instrF,    32'hC0DE_0000);
    check("t1_p0",   pcPlus4F,  32'h4);
    check("t1_a4",   imem_addr, 32'h4);
    tick();
    check("t1_i4",   instrF,    32'hC0DE_0004);
    check("t1_a8",   imem_addr, 32'h8);
    tick();
    check("t1_i8",   instrF,    32'hC0DE_0008);
    check("t1_ac",   imem_addr, 32'hC);

    // 2: stall fills queue, request drops, then drains in order
    stallF = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_req_off", {31'h0, imem_req}, 32'h0);
      check("t2_head",    instrF, 32'hC0DE_0008);
    end
    stallF = 1'b0;
    tick();
    check("t2_pop1",  instrF,    32'hC0DE_000C);
    check("t2_resume",imem_addr, 32'h10);
    check("t2_req_on",{31'h0, imem_req}, 32'h1);
    tick();
    check("t2_pop2",  instrF,    32'hC0DE_0010);
    check("t2_a14",   imem_addr, 32'h14);

    // 3: delayed ack with redirect in the first wait cycle
    ack_en = 1'b0;
    tick();
    check("t3_empty", {31'h0, validF}, 32'h0);
    check("t3_wait",  imem_addr, 32'h14);
    pcSrcD = 1'b1; pcBranchD = 32'h100;
    tick();
    pcSrcD = 1'b0;
    check("t3_hold1", imem_addr, 32'h14);
    check("t3_req1",  {31'h0, imem_req}, 32'h1);
    tick();
    check("t3_hold2", imem_addr, 32'h14);
    ack_en = 1'b1;
    tick();
    check("t3_noStale", {31'h0, validF}, 32'h0);
    check("t3_tgt",     imem_addr, 32'h100);
    tick();
    check("t3_v",   {31'h0, validF}, 32'h1);
    check("t3_i",   instrF,   32'hC0DE_0100);
    check("t3_p",   pcPlus4F, 32'h104);

    // 4: two redirects in one DROP, latest wins
    ack_en = 1'b0;
    tick();
    pcSrcD = 1'b1; pcBranchD = 32'h100;
    tick();
    pcBranchD = 32'h200;
    tick();
    pcSrcD = 1'b0;
    check("t4_hold", imem_addr, 32'h104);
    ack_en = 1'b1;
    tick();
    check("t4_tgt",  imem_addr, 32'h200);
    check("t4_v0",   {31'h0, validF}, 32'h0);
    tick();
    check("t4_i",    instrF, 32'hC0DE_0200);

    // 5: redirect with ack and pop in the same cycle, then redirect from a full queue
    pcSrcD = 1'b1; pcBranchD = 32'h300;
    tick();
    pcSrcD = 1'b0;
    check("t5_v0",   {31'h0, validF}, 32'h0);
    check("t5_i0",   instrF, 32'h0);
    check("t5_tgt",  imem_addr, 32'h300);
    tick();
    check("t5_i",    instrF, 32'hC0DE_0300);
    stallF = 1'b1;
    tick();
    check("t5_full", {31'h0, imem_req}, 32'h0);
    pcSrcD = 1'b1; pcBranchD = 32'h400;
    tick();
    pcSrcD = 1'b0; stallF = 1'b0;
    check("t5_fv0",  {31'h0, validF}, 32'h0);
    check("t5_faddr",imem_addr, 32'h400);
    tick();
    check("t5_fi",   instrF, 32'hC0DE_0400);

    // PC wrap
    pcSrcD = 1'b1; pcBranchD = 32'hFFFF_FFFC;
    tick();
    pcSrcD = 1'b0;
    check("w_addr",  imem_addr, 32'hFFFF_FFFC);
    tick();
    check("w_i",     instrF,    32'hC0DE_FFFC);
    check("w_p4",    pcPlus4F,  32'h0);
    check("w_next",  imem_addr, 32'h0);
    tick();
    check("w_a4",    imem_addr, 32'h4);

    // 6: reset during DROP
    ack_en = 1'b0; pcSrcD = 1'b1; pcBranchD = 32'h500;
    tick();
    pcSrcD = 1'b0;
    check("t6_drop", imem_addr, 32'h4);
    rst = 1'b1;
    #1;
    check("t6_req",  {31'h0, imem_req}, 32'h0);
    check("t6_addr", imem_addr, 32'h0);
    check("t6_v",    {31'h0, validF}, 32'h0);
    tick();
    rst = 1'b0; ack_en = 1'b1;
    #1;
    check("t6_rel",  {31'h0, imem_req}, 32'h0);
    tick();
    check("t6_a0",   imem_addr, 32'h0);
    check("t6_req1", {31'h0, imem_req}, 32'h1);
    tick();
    check("t6_i0",   instrF, 32'hC0DE_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
